// File: rtl/obstacle_pkg.sv
// Shared definitions for the runner's pseudo-random generators and scroll timing.
package obstacle_pkg;

  localparam int unsigned LFSR_W    = 16;
  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to bits 0,2,3,5.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  localparam int unsigned PERIOD_W  = 32;

  // Keep the low `lanes` bits and guarantee at least one free lane.
  function automatic logic [LFSR_W-1:0] make_passable(input logic [LFSR_W-1:0] row,
                                                      input int unsigned lanes);
    logic [LFSR_W-1:0] mask;
    logic [LFSR_W-1:0] r;
    mask = LFSR_W'((32'd1 << lanes) - 32'd1);
    r    = row & mask;
    if (r == mask) r &= ~(16'd1 << (lanes - 1));
    return r;
  endfunction

endpackage

// File: rtl/obstacle_field_if.sv
// Field-to-consumer bundle: pause control in, field contents and scroll timing out.
interface obstacle_field_if
  import obstacle_pkg::*;
#(
  parameter int unsigned LANES = 3,
  parameter int unsigned DEPTH = 4
);
  logic                   en;
  logic [LANES*DEPTH-1:0] rows;
  logic                   tick;
  logic [PERIOD_W-1:0]    period;

  modport master (input en, output rows, output tick, output period);
  modport slave  (output en, input rows, input tick, input period);
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free-running every non-reset clock; loads seed on reset.
module lfsr16
  import obstacle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);
  logic [LFSR_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= seed;
    else     r_q <= {^(r_q & LFSR_TAPS), r_q[LFSR_W-1:1]};
  end

  assign q = r_q;
endmodule

// File: rtl/obstacle_field.sv
// Scrolling obstacle field: spawns LFSR rows separated by GAP empty rows and
// ramps the scroll period down to END_CYCLES; en=0 freezes everything but the LFSR.
module obstacle_field
  import obstacle_pkg::*;
#(
  parameter int unsigned       LANES        = 3,
  parameter int unsigned       DEPTH        = 4,
  parameter int unsigned       START_CYCLES = 60_000_000,
  parameter int unsigned       END_CYCLES   = 30_000_000,
  parameter int unsigned       STEP         = 500_000,
  parameter int unsigned       GAP          = 1,
  parameter logic [LFSR_W-1:0] SEED         = LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst,
  obstacle_field_if.master  bus
);
  localparam logic [PERIOD_W-1:0] P_START  = PERIOD_W'(START_CYCLES);
  localparam logic [PERIOD_W-1:0] P_END    = PERIOD_W'(END_CYCLES);
  localparam logic [PERIOD_W-1:0] P_STEP   = PERIOD_W'(STEP);
  localparam logic [PERIOD_W-1:0] P_GAP    = PERIOD_W'(GAP);
  // One extra bit so END_CYCLES+STEP cannot wrap.
  localparam logic [PERIOD_W:0]   P_THRESH = (PERIOD_W+1)'(END_CYCLES) + (PERIOD_W+1)'(STEP);

  logic [LFSR_W-1:0]               w_lfsr;
  logic                            w_term;
  logic [LANES-1:0]                w_new_row;
  logic [PERIOD_W-1:0]             r_count;
  logic [PERIOD_W-1:0]             r_period;
  logic [PERIOD_W-1:0]             r_gap;
  logic                            r_tick;
  logic [DEPTH-1:0][LANES-1:0]     r_rows;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (w_lfsr)
  );

  assign w_term    = bus.en && (r_count == r_period - 1'b1);
  assign w_new_row = LANES'(make_passable((r_gap != '0) ? '0 : w_lfsr, LANES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_period <= P_START;
      r_gap    <= '0;
      r_tick   <= 1'b0;
      r_rows   <= '0;
    end else begin
      r_tick <= 1'b0;
      if (w_term) begin
        r_count <= '0;
        r_tick  <= 1'b1;
        r_rows  <= {r_rows[DEPTH-2:0], w_new_row};
        r_gap   <= (r_gap != '0) ? r_gap - 1'b1 : P_GAP;
        if (r_period > P_END)
          r_period <= ({1'b0, r_period} > P_THRESH) ? r_period - P_STEP : P_END;
      end else if (bus.en) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.rows   = r_rows;
  assign bus.tick   = r_tick;
  assign bus.period = r_period;
endmodule
